muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if -- request/response bundle between the EX stage and muldiv_unit.
//   master : EX stage / pipeline control (drives request, flush, resp_ready)
//   slave  : muldiv_unit (drives req_ready, resp_valid, result)
`ifndef WIDTH
`define WIDTH 32
`endif

interface muldiv_if;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [`WIDTH-1:0]  op1;
    logic [`WIDTH-1:0]  op2;
    logic               flush;
    logic               resp_valid;
    logic               resp_ready;
    logic [`WIDTH-1:0]  result;

    modport master (
        output req_valid, req_op, op1, op2, flush, resp_ready,
        input  req_ready, resp_valid, result
    );

    modport slave (
        input  req_valid, req_op, op1, op2, flush, resp_ready,
        output req_ready, resp_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative signed multiply / divide, one bit per clock.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : req_valid/req_ready/req_op/op1/op2 request,
//                  flush abort, resp_valid/resp_ready/result response
// Ops: 00 MUL low word, 01 MULH signed high word, 10 DIV, 11 REM.
// Both multiply and divide run on operand magnitudes; the sign is applied
// once on the final iteration.
`ifndef WIDTH
`define WIDTH 32
`endif

module muldiv_unit (
    input  logic      clock,
    input  logic      reset,
    muldiv_if.slave   bus
);
    localparam int W  = `WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [W:0]    hi_q;   // mul: upper partial product + carry; div: partial remainder
    logic [W-1:0]  lo_q;   // mul: multiplier / low product; div: dividend -> quotient
    logic [W-1:0]  d_q;    // mul: multiplicand magnitude; div: divisor magnitude
    logic [1:0]    op_q;
    logic          neg_q;  // signs differ: negate product / quotient
    logic          sgn_q;  // dividend sign: negate remainder
    logic [W-1:0]  res_q;
    logic [CW-1:0] cnt;

    logic          accept, special, last;
    logic [W-1:0]  mag1, mag2, spec_res;

    assign accept  = bus.req_valid && (state == IDLE) && !bus.flush;
    assign mag1    = bus.op1[W-1] ? -bus.op1 : bus.op1;
    assign mag2    = bus.op2[W-1] ? -bus.op2 : bus.op2;
    // Divide by zero and MIN/-1 bypass the iteration entirely.
    assign special = bus.req_op[1] &&
                     ((bus.op2 == '0) || (bus.op1 == MIN_INT && bus.op2 == '1));
    assign spec_res = (bus.op2 == '0) ? (bus.req_op[0] ? bus.op1 : '1)
                                      : (bus.req_op[0] ? '0 : MIN_INT);
    assign last    = (cnt == CW'(W-1));

    // One iteration step plus the signed result it would produce if final.
    logic [W:0]     sum, shl, diff, hi_n;
    logic [W-1:0]   lo_n, quo, rem, fin;
    logic [2*W-1:0] prod;

    always_comb begin
        sum  = {1'b0, hi_q[W-1:0]} + (lo_q[0] ? {1'b0, d_q} : '0);
        shl  = {hi_q[W-1:0], lo_q[W-1]};
        diff = shl - {1'b0, d_q};
        if (op_q[1]) begin
            // Restoring divide: bit W of diff is the borrow (shl < divisor).
            hi_n = diff[W] ? shl : diff;
            lo_n = {lo_q[W-2:0], ~diff[W]};
        end else begin
            hi_n = {1'b0, sum[W:1]};
            lo_n = {sum[0], lo_q[W-1:1]};
        end
        prod = {hi_n[W-1:0], lo_n};
        if (neg_q) prod = -prod;
        quo  = neg_q ? -lo_n : lo_n;
        rem  = sgn_q ? -hi_n[W-1:0] : hi_n[W-1:0];
        case (op_q)
            2'b00:   fin = prod[W-1:0];
            2'b01:   fin = prod[2*W-1:W];
            2'b10:   fin = quo;
            default: fin = rem;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state; flush overrides everything
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept)         state_n = special ? DONE : BUSY;
            BUSY: if (last)           state_n = DONE;
            DONE: if (bus.resp_ready) state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
        if (bus.flush) state_n = IDLE;
    end

    // Outputs
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == DONE);
        bus.result     = (state == DONE) ? res_q : '0;
    end

    // Datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            d_q   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            sgn_q <= 1'b0;
            res_q <= '0;
            cnt   <= '0;
        end else if (accept) begin
            op_q  <= bus.req_op;
            hi_q  <= '0;
            d_q   <= bus.req_op[1] ? mag2 : mag1;
            lo_q  <= bus.req_op[1] ? mag1 : mag2;
            neg_q <= bus.op1[W-1] ^ bus.op2[W-1];
            sgn_q <= bus.op1[W-1];
            cnt   <= '0;
            if (special) res_q <= spec_res;
        end else if (state == BUSY && !bus.flush) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt + CW'(1);
            if (last) res_q <= fin;
        end
    end
endmodule
